// File: rtl/bin_adaptive_stream.sv
// bin_adaptive_stream: two-pass adaptive-threshold binariser built on an integral image
module bin_adaptive_stream #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8,
    parameter int RAD_W = 8
) (
    input  logic             bin_clk,
    input  logic             bin_rst,
    input  logic             start,
    input  logic [RAD_W-1:0] radius,
    input  logic [6:0]       sens,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_in_valid,
    output logic             pix_in_ready,
    output logic             bin_data,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             bin_last,
    output logic             frame_done,
    output logic [1:0]       condition_led
);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int SUM_W = PIX_W + XW + YW;
    localparam int CW    = SUM_W + 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = $clog2(NPIX);
    localparam int XYW   = (XW > YW) ? XW : YW;
    localparam int MW    = ((XYW > RAD_W) ? XYW : RAD_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [2:0]         r_ph;
    logic [RAD_W-1:0]   r_rad;
    logic [6:0]         r_k;
    logic [SUM_W-1:0]   r_rsum, r_sum, r_iq;
    logic [PIX_W-1:0]   r_pq;
    logic               r_bv, r_bd;
    logic [SUM_W-1:0]   r_prev [IMG_W];
    logic [SUM_W-1:0]   r_imem [NPIX];
    logic [PIX_W-1:0]   r_pmem [NPIX];

    logic               w_acc, w_hs, w_xl, w_yl, w_rd, w_x0z, w_y0z, w_cmp;
    logic [MW-1:0]      w_xm, w_ym, w_r, w_x0, w_x1, w_y0, w_y1, w_x0m, w_y0m, w_rx, w_ry;
    logic [AW-1:0]      w_addr;
    logic [SUM_W-1:0]   w_rs, w_iv;
    logic [CW-1:0]      w_ax, w_ay, w_area, w_lhs, w_rhs;

    assign w_acc = (r_state == S_LOAD) && pix_in_valid;
    assign w_hs  = r_bv && bin_ready;
    assign w_xl  = r_x == XW'(IMG_W - 1);
    assign w_yl  = r_y == YW'(IMG_H - 1);

    // Window bounds clamped to the frame; compare first so nothing wraps
    assign w_xm  = MW'(r_x);
    assign w_ym  = MW'(r_y);
    assign w_r   = MW'(r_rad);
    assign w_x0  = (w_xm > w_r) ? w_xm - w_r : '0;
    assign w_y0  = (w_ym > w_r) ? w_ym - w_r : '0;
    assign w_x1  = (w_r >= MW'(IMG_W - 1) - w_xm) ? MW'(IMG_W - 1) : w_xm + w_r;
    assign w_y1  = (w_r >= MW'(IMG_H - 1) - w_ym) ? MW'(IMG_H - 1) : w_ym + w_r;
    assign w_x0z = w_x0 == '0;
    assign w_y0z = w_y0 == '0;
    assign w_x0m = w_x0z ? '0 : w_x0 - MW'(1);
    assign w_y0m = w_y0z ? '0 : w_y0 - MW'(1);

    // Phases 0..3 read the four corners, phase 4 reads the pixel; LOAD writes at (y,x)
    assign w_rd   = (r_state == S_CALC) && (r_ph < 3'd4);
    assign w_ry   = !w_rd ? w_ym : r_ph[0] ? w_y0m : w_y1;
    assign w_rx   = !w_rd ? w_xm : r_ph[1] ? w_x0m : w_x1;
    assign w_addr = AW'(w_ry) * AW'(IMG_W) + AW'(w_rx);

    assign w_rs = (r_x == '0 ? '0 : r_rsum) + SUM_W'(pix_in);
    assign w_iv = w_rs + (r_y == '0 ? '0 : r_prev[r_x]);

    assign w_ax   = CW'(w_x1 - w_x0) + CW'(1);
    assign w_ay   = CW'(w_y1 - w_y0) + CW'(1);
    assign w_area = w_ax * w_ay;
    assign w_lhs  = (CW'(r_pq) * w_area) << 7;
    assign w_rhs  = CW'(r_sum) * CW'(8'd128 - {1'b0, r_k});
    assign w_cmp  = w_lhs >= w_rhs;

    assign pix_in_ready  = r_state == S_LOAD;
    assign condition_led = {r_state == S_CALC, r_state == S_LOAD};
    assign frame_done    = r_state == S_DONE;
    assign bin_valid     = r_bv;
    assign bin_data      = r_bd;
    assign bin_last      = r_bv && w_xl && w_yl;

    // State register
    always_ff @(posedge bin_clk) begin
        r_state <= bin_rst ? S_IDLE : w_next;
    end

    // Next-state: frame load, per-pixel calc, single-cycle done
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (w_acc && w_xl && w_yl) w_next = S_CALC;
            S_CALC:  if (w_hs && w_xl && w_yl) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counters, run-time settings, row sum and the per-pixel calc sequence
    always_ff @(posedge bin_clk) begin
        if (bin_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_ph   <= '0;
            r_rad  <= '0;
            r_k    <= '0;
            r_rsum <= '0;
            r_sum  <= '0;
            r_bv   <= 1'b0;
            r_bd   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_rad <= radius;
                r_k   <= sens;
                r_x   <= '0;
                r_y   <= '0;
                r_ph  <= '0;
            end
            if (w_acc) r_rsum <= w_rs;
            if (w_acc || w_hs) begin
                r_x <= w_xl ? '0 : r_x + 1'b1;
                if (w_xl) r_y <= w_yl ? '0 : r_y + 1'b1;
            end
            if (r_state == S_CALC) begin
                if (r_ph < 3'd6) r_ph <= r_ph + 3'd1;
                else if (w_hs) begin
                    r_ph <= '0;
                    r_bv <= 1'b0;
                end
                if (r_ph == 3'd1) r_sum <= r_iq;
                if (r_ph == 3'd2 && !w_y0z) r_sum <= r_sum - r_iq;
                if (r_ph == 3'd3 && !w_x0z) r_sum <= r_sum - r_iq;
                if (r_ph == 3'd4 && !w_x0z && !w_y0z) r_sum <= r_sum + r_iq;
                if (r_ph == 3'd5) begin
                    r_bv <= 1'b1;
                    r_bd <= w_cmp;
                end
            end
        end
    end

    // Previous-row integral values, feeding the vertical accumulation
    always_ff @(posedge bin_clk) begin
        if (w_acc) r_prev[r_x] <= w_iv;
    end

    // Integral-image RAM: single port, registered read
    always_ff @(posedge bin_clk) begin
        if (w_acc) r_imem[w_addr] <= w_iv;
        r_iq <= r_imem[w_addr];
    end

    // Pixel RAM: single port, registered read
    always_ff @(posedge bin_clk) begin
        if (w_acc) r_pmem[w_addr] <= pix_in;
        r_pq <= r_pmem[w_addr];
    end
endmodule

// File: tb/tb_bin_adaptive_stream.sv
// tb_bin_adaptive_stream: scoreboard bench for a 4x4 frame with directed images
module tb_bin_adaptive_stream;
    logic       bin_clk = 1'b0;
    logic       bin_rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] radius = '0;
    logic [6:0] sens = '0;
    logic [7:0] pix_in = '0;
    logic       pix_in_valid = 1'b0;
    logic       bin_ready = 1'b1;
    logic       pix_in_ready, bin_data, bin_valid, bin_last, frame_done;
    logic [1:0] condition_led;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [1:0] q[$];
    logic [7:0] img [16];
    bit         done_seen = 1'b0;

    int         cyc = 0;
    int         prev_cyc = 0;
    int         n_out = 0;
    bit         have_prev = 1'b0;
    bit         stalled = 1'b0;
    bit         hold = 1'b0;
    bit         exp_done = 1'b0;
    logic       p_data = 1'b0;
    logic [1:0] e;

    bin_adaptive_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .RAD_W(8)) dut (
        .bin_clk(bin_clk), .bin_rst(bin_rst), .start(start), .radius(radius), .sens(sens),
        .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .bin_data(bin_data), .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_last(bin_last),
        .frame_done(frame_done), .condition_led(condition_led)
    );

    always #5 bin_clk = ~bin_clk;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 16; i++)
            img[i] = (mode == 0) ? 8'd100 : (mode == 1) ? ((i == 5) ? 8'd200 : 8'd0) : 8'((i % 4) * 50);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pix_in_ready"}, int'(pix_in_ready), 0);
        chk({tag, "_bin_valid"}, int'(bin_valid), 0);
        chk({tag, "_bin_data"}, int'(bin_data), 0);
        chk({tag, "_bin_last"}, int'(bin_last), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_led"}, int'(condition_led), 0);
    endtask

    task automatic run_frame(input int r, input int k, input logic [15:0] mask, input bit stall, input bit poke);
        done_seen = 1'b0;
        @(posedge bin_clk); #1;
        start = 1'b1; radius = 8'(r); sens = 7'(k);
        @(posedge bin_clk); #1;
        start = 1'b0; radius = 8'hAA; sens = 7'h55;
        chk("load_led", int'(condition_led), 1);
        chk("load_ready", int'(pix_in_ready), 1);
        for (int i = 0; i < 16; i++) q.push_back({i == 15, mask[i]});
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                pix_in_valid = 1'b0;
                @(posedge bin_clk); #1;
            end
            pix_in = img[i];
            pix_in_valid = 1'b1;
            @(posedge bin_clk); #1;
        end
        pix_in_valid = 1'b0;
        chk("calc_led", int'(condition_led), 2);
        if (poke) begin
            repeat (10) @(posedge bin_clk);
            #1 start = 1'b1; radius = 8'd0; sens = 7'd0;
            @(posedge bin_clk);
            #1 start = 1'b0;
            chk("calc_led_after_start", int'(condition_led), 2);
        end
        if (stall) begin
            repeat (30) @(posedge bin_clk);
            #1 bin_ready = 1'b0;
            repeat (20) @(posedge bin_clk);
            #1 bin_ready = 1'b1;
        end
        for (int c = 0; c < 400 && !done_seen; c++) @(posedge bin_clk);
        chk("frame_complete", int'(done_seen), 1);
        chk("queue_drained", q.size(), 0);
        q.delete();
        @(posedge bin_clk); #1;
        chk("idle_led", int'(condition_led), 0);
    endtask

    initial begin
        forever begin
            @(negedge bin_clk);
            cyc++;
            if (bin_rst) begin
                hold = 1'b0;
                exp_done = 1'b0;
                have_prev = 1'b0;
                continue;
            end
            if (exp_done) begin
                chk("frame_done_pulse", int'(frame_done), 1);
                done_seen = 1'b1;
                exp_done = 1'b0;
            end else if (frame_done) begin
                chk("frame_done_unexpected", int'(frame_done), 0);
            end
            if (hold) chk("hold_under_backpressure", int'({bin_valid, bin_data}), int'({1'b1, p_data}));
            if (bin_valid && bin_ready) begin
                if (q.size() == 0) chk("extra_output", q.size(), 1);
                else begin
                    e = q.pop_front();
                    chk($sformatf("pixel%0d_last_data", n_out % 16), int'({bin_last, bin_data}), int'(e));
                end
                if (have_prev && !stalled) chk("output_gap", cyc - prev_cyc, 7);
                n_out++;
                prev_cyc = cyc;
                have_prev = !bin_last;
                stalled = 1'b0;
                exp_done = bin_last;
            end
            hold = bin_valid && !bin_ready;
            if (hold) begin
                stalled = 1'b1;
                p_data = bin_data;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge bin_clk);
        #1 chk_idle_outputs("reset");
        bin_rst = 1'b0;
        fill(0);
        run_frame(1, 0, 16'hFFFF, 1'b0, 1'b0);
        fill(1);
        run_frame(1, 0, 16'hF8A8, 1'b0, 1'b1);
        fill(2);
        run_frame(0, 0, 16'hFFFF, 1'b0, 1'b0);
        run_frame(1, 64, 16'hEEEE, 1'b1, 1'b0);
        fill(1);
        run_frame(255, 0, 16'h0020, 1'b0, 1'b0);
        fill(2);
        run_frame(200, 0, 16'hCCCC, 1'b0, 1'b0);
        @(posedge bin_clk); #1;
        start = 1'b1; radius = 8'd1; sens = 7'd0;
        @(posedge bin_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pix_in = img[i];
            pix_in_valid = 1'b1;
            @(posedge bin_clk); #1;
        end
        bin_rst = 1'b1;
        pix_in_valid = 1'b0;
        @(posedge bin_clk); #1;
        chk_idle_outputs("abort");
        bin_rst = 1'b0;
        run_frame(1, 64, 16'hEEEE, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule
